pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One instance carries a packed control vector plus a packed datapath vector between two CPU stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stall logic is fully registered.
- Adds per-stage flush (bubble insertion) and a stall-cycle performance counter that the old enable/reset register lacks.

---
 rtl/pipe_stage_elastic_pkg.sv | 39 +++
 rtl/pipe_stage_elastic_sat_counter.sv | 20 ++
 rtl/pipe_stage_elastic.sv | 105 ++++++++++
 tb/tb_pipe_stage_elastic.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for elastic inter-stage pipeline registers: per-boundary payload
// structs, the widths derived from them, and the two-entry occupancy encoding.
package pipe_stage_elastic_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [4:0] rd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
  } id_ex_data_t;

  localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
  localparam int ID_EX_DATA_W = $bits(id_ex_data_t);

  // Encoded as {main_valid, skid_valid}; 2'b01 is unreachable by construction.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } stage_state_t;

  function automatic logic [1:0] occ_of(input stage_state_t s);
    return {1'b0, s[1]} + {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_stage_elastic_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst)                       count <= '0;
    else if (clr)                   count <= '0;
    else if (inc && (count != '1))  count <= count + W'(1);
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer,
// per-stage flush (bubble insertion) and a saturating stall-cycle counter.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int CTRL_W     = ID_EX_CTRL_W,
  parameter int DATA_W     = ID_EX_DATA_W,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [PERF_W-1:0] stall_cnt,
  input  logic              stall_clr
);

  stage_state_t      state;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_xfer, out_xfer;

  // Every output below is a flop or a function of flops only.
  assign in_ready  = ~state[0];
  assign out_valid = state[1];
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_of(state);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide data registers are reset too; downstream stages may
      // observe out_data while out_valid=0 and must see a defined value.
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      // NOTE: the default arm keeps the decode fully specified; any
      // unreachable encoding recovers to EMPTY instead of holding garbage.
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state     <= ST_ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_xfer) begin
            state     <= ST_TWO;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_xfer) begin
            // Clearing ctrl here keeps out_ctrl=0 whenever out_valid=0.
            state     <= ST_EMPTY;
            main_ctrl <= '0;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state     <= ST_ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  pipe_stage_elastic_sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stall_clr),
    .inc   (out_valid & ~out_ready & ~flush),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed vector table, hand-written
// corner sequences and a random run, all against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int CW = 16;
  localparam int DW = 160;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;
  logic [PW-1:0] stall0, stall1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .PERF_W(PW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0), .stall_cnt(stall0),
    .stall_clr(stall_clr));

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .PERF_W(PW)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1), .stall_cnt(stall1),
    .stall_clr(stall_clr));

  // Reference model: queue of held entries plus last-main-data shadows.
  logic [CW-1:0] mq_c[$];
  logic [DW-1:0] mq_d[$];
  logic [DW-1:0] m_data0 = '0, m_data1 = '0;
  logic [PW-1:0] m_stall = '0;

  typedef struct {
    logic          rst, iv, ordy, fl, sclr;
    logic [CW-1:0] c;
    logic          e_ov;
    logic [CW-1:0] e_ctrl;
    logic [1:0]    e_occ;
    logic          e_ird;
  } vec_t;

  vec_t tv[19];

  function automatic logic [DW-1:0] mk_data(input logic [CW-1:0] c);
    return {10{c}};
  endfunction

  function automatic vec_t mk(input logic r, iv, ordy, fl, input logic [CW-1:0] c,
                              input logic ov, input logic [CW-1:0] ec,
                              input logic [1:0] occ, input logic ird);
    vec_t v;
    v.rst = r; v.iv = iv; v.ordy = ordy; v.fl = fl; v.sclr = 1'b0; v.c = c;
    v.e_ov = ov; v.e_ctrl = ec; v.e_occ = occ; v.e_ird = ird;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, iv, ordy, fl, sclr, input logic [CW-1:0] c);
    rst = r; in_valid = iv; out_ready = ordy; flush = fl; stall_clr = sclr;
    in_ctrl = c; in_data = mk_data(c);
  endtask

  // One clock: update the model from the driven inputs, then compare at negedge.
  task automatic cycle();
    bit ov, in_x, out_x;
    logic [CW-1:0] e_ctrl;
    @(posedge clk);
    ov    = mq_c.size() > 0;
    in_x  = in_valid && (mq_c.size() < 2);
    out_x = ov && out_ready;
    if (!rst) begin
      mq_c.delete(); mq_d.delete();
      m_data0 = '0; m_data1 = '0; m_stall = '0;
    end else begin
      if (stall_clr) m_stall = '0;
      else if (ov && !out_ready && !flush && m_stall != '1) m_stall = m_stall + 1'b1;
      if (flush) begin
        mq_c.delete(); mq_d.delete();
        m_data1 = '0;
      end else begin
        if (out_x) begin void'(mq_c.pop_front()); void'(mq_d.pop_front()); end
        if (in_x)  begin mq_c.push_back(in_ctrl); mq_d.push_back(in_data); end
      end
      if (mq_d.size() > 0) begin m_data0 = mq_d[0]; m_data1 = mq_d[0]; end
    end
    @(negedge clk);
    e_ctrl = (mq_c.size() > 0) ? mq_c[0] : '0;
    check("out_valid",  DW'(out_valid0), DW'(mq_c.size() > 0));
    check("in_ready",   DW'(in_ready0),  DW'(mq_c.size() < 2));
    check("occupancy",  DW'(occ0),       DW'(mq_c.size()));
    check("out_ctrl",   DW'(out_ctrl0),  DW'(e_ctrl));
    check("out_data",   out_data0,       m_data0);
    check("stall_cnt",  DW'(stall0),     DW'(m_stall));
    check("cd1_valid",  DW'(out_valid1), DW'(mq_c.size() > 0));
    check("cd1_ctrl",   DW'(out_ctrl1),  DW'(e_ctrl));
    check("cd1_data",   out_data1,       m_data1);
    check("cd1_stall",  DW'(stall1),     DW'(m_stall));
  endtask

  initial begin
    // Reset then stream 1..5 with out_ready high.
    tv[0]  = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
    tv[1]  = mk(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
    tv[2]  = mk(1, 1, 1, 0, 16'h0001, 1, 16'h0001, 2'd1, 1);
    tv[3]  = mk(1, 1, 1, 0, 16'h0002, 1, 16'h0002, 2'd1, 1);
    tv[4]  = mk(1, 1, 1, 0, 16'h0003, 1, 16'h0003, 2'd1, 1);
    tv[5]  = mk(1, 1, 1, 0, 16'h0004, 1, 16'h0004, 2'd1, 1);
    tv[6]  = mk(1, 1, 1, 0, 16'h0005, 1, 16'h0005, 2'd1, 1);
    tv[7]  = mk(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
    // Backpressure: A in main, B in skid, C refused until drained.
    tv[8]  = mk(1, 1, 0, 0, 16'h00A1, 1, 16'h00A1, 2'd1, 1);
    tv[9]  = mk(1, 1, 0, 0, 16'h00B2, 1, 16'h00A1, 2'd2, 0);
    tv[10] = mk(1, 1, 0, 0, 16'h00C3, 1, 16'h00A1, 2'd2, 0);
    tv[11] = mk(1, 1, 1, 0, 16'h00C3, 1, 16'h00B2, 2'd1, 1);
    tv[12] = mk(1, 1, 1, 0, 16'h00C3, 1, 16'h00C3, 2'd1, 1);
    tv[13] = mk(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);
    // Flush with both entries full, then flush an accepted input on EMPTY.
    tv[14] = mk(1, 1, 0, 0, 16'h00D4, 1, 16'h00D4, 2'd1, 1);
    tv[15] = mk(1, 1, 0, 0, 16'h00E5, 1, 16'h00D4, 2'd2, 0);
    tv[16] = mk(1, 1, 0, 1, 16'h00F6, 0, 16'h0000, 2'd0, 1);
    tv[17] = mk(1, 1, 0, 1, 16'h0007, 0, 16'h0000, 2'd0, 1);
    tv[18] = mk(1, 0, 1, 0, 16'h0000, 0, 16'h0000, 2'd0, 1);

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].rst, tv[i].iv, tv[i].ordy, tv[i].fl, tv[i].sclr, tv[i].c);
      cycle();
      check($sformatf("tv%0d.out_valid", i), DW'(out_valid0), DW'(tv[i].e_ov));
      check($sformatf("tv%0d.out_ctrl", i),  DW'(out_ctrl0),  DW'(tv[i].e_ctrl));
      check($sformatf("tv%0d.occupancy", i), DW'(occ0),       DW'(tv[i].e_occ));
      check($sformatf("tv%0d.in_ready", i),  DW'(in_ready0),  DW'(tv[i].e_ird));
    end
    check("flush_data_hold", out_data0, mk_data(16'h00D4));
    check("flush_data_zero", out_data1, '0);

    // Stall counter saturation, then clear during a stall.
    drive(1, 1, 1, 0, 1, 16'h0011);
    cycle();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 16'h0000);
      cycle();
    end
    check("stall_sat", DW'(stall0), DW'(4'hF));
    drive(1, 0, 0, 0, 1, 16'h0000);
    cycle();
    check("stall_clr_win", DW'(stall0), '0);
    drive(1, 0, 1, 0, 0, 16'h0000);
    cycle();

    // Reset in TWO with flush asserted.
    drive(1, 1, 0, 0, 0, 16'h0021);
    cycle();
    drive(1, 1, 0, 0, 0, 16'h0022);
    cycle();
    check("pre_rst_occ", DW'(occ0), DW'(2'd2));
    drive(0, 1, 0, 1, 0, 16'h0023);
    cycle();
    check("rst_out_valid", DW'(out_valid0), '0);
    check("rst_in_ready",  DW'(in_ready0),  DW'(1'b1));
    check("rst_occ",       DW'(occ0),       '0);
    check("rst_ctrl",      DW'(out_ctrl0),  '0);
    check("rst_data",      out_data0,       '0);
    check("rst_stall",     DW'(stall0),     '0);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      drive(logic'($urandom_range(0, 999) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 63) == 0), 16'($urandom));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
